uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
- Sits directly after the UART receiver and consumes its byte-done pulse and data byte.
- Sequences received bytes into framed packets: SOF, LEN, PAYLOAD[LEN], CHK.
- Buffers the payload, checks length and XOR checksum, and enforces an inter-byte timeout using the baud oversample tick.
- Drains validated payloads to a downstream consumer over a valid/ready handshake.

Parameters:
- SOF, 8'hA5, start-of-frame marker byte.
- MAX_LEN, 16, maximum payload bytes (1..255); also the buffer depth.
- TIMEOUT_TICKS, 2560, s_tick count allowed between bytes inside a frame (1..65535); default is 16 byte-times at 16x oversampling.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_tick  in  1  baud oversample tick, shared with the UART receiver.
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  8  received byte.
- m_valid  out  1  payload byte available.
- m_ready  in  1  consumer accepts the byte.
- m_data  out  8  payload byte.
- m_last  out  1  marks the final payload byte of a frame.
- frame_ok  out  1  pulse: frame validated.
- err_len  out  1  pulse: LEN = 0 or LEN > MAX_LEN.
- err_chk  out  1  pulse: checksum mismatch.
- err_timeout  out  1  pulse: inter-byte timeout expired.
- overrun  out  1  pulse: byte dropped while draining.
- busy  out  1  high in any state other than IDLE.
- stat_frames  out  16  good-frame count (see Optional Feature).
- stat_errors  out  16  error count (see Optional Feature).

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. A reset mid-frame or mid-drain discards everything with no error pulse.
- States: IDLE, LEN, PAYLOAD, CHK, DRAIN. All byte events are qualified by rx_done_tick.
- IDLE: a byte equal to SOF moves to LEN. All other bytes are ignored silently.
- LEN: latch len and set chk_acc = len.
  - If len = 0 or len > MAX_LEN: pulse err_len and return to IDLE.
  - Otherwise go to PAYLOAD.
- PAYLOAD: write the byte to buf[idx], then idx++ and chk_acc ^= byte. After the len-th byte, go to CHK.
- CHK:
  - If the byte equals chk_acc: pulse frame_ok and go to DRAIN with rd_idx = 0.
  - Otherwise pulse err_chk and return to IDLE.
- Pulse timing: all pulses are registered, exactly one cycle wide, and occur in the cycle after the triggering rx_done_tick.
- DRAIN:
  - m_valid = 1 and m_data = buf[rd_idx] (registered read, stable while valid).
  - m_last = 1 when rd_idx = len-1.
  - A transfer occurs on m_valid & m_ready; rd_idx then increments.
  - After the transfer with m_last, return to IDLE in the next cycle with m_valid = 0.
  - m_data and m_last hold while m_valid & !m_ready.
  - An rx_done_tick in DRAIN drops the byte and pulses overrun (even if the byte is SOF).
- Timeout:
  - In LEN, PAYLOAD and CHK, a 16-bit counter increments on s_tick and clears on rx_done_tick.
  - When the counter reaches TIMEOUT_TICKS-1 and another s_tick arrives: pulse err_timeout and return to IDLE.
  - If rx_done_tick and the expiring s_tick coincide, the byte wins: it is processed and the counter clears.
  - The counter is held at 0 in IDLE and DRAIN.
- Widths:
  - idx, rd_idx and len use $clog2(MAX_LEN+1) bits internally; LEN compare uses the full 8 bits.
  - The checksum is the 8-bit XOR of LEN and all payload bytes.
- Frame latency: m_valid rises in the same cycle as frame_ok. A back-to-back drain with m_ready held high takes len cycles.

Optional Feature:
- Macro: UART_FRAME_STATS_EN.
- Defined:
  - stat_frames increments on each frame_ok.
  - stat_errors increments on each err_len, err_chk, err_timeout or overrun pulse.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: no counter logic; stat_frames and stat_errors are tied to 16'h0000.

Decomposition:
- Package uart_frame_pkg: state encoding constants (IDLE=3'd0, LEN=3'd1, PAYLOAD=3'd2, CHK=3'd3, DRAIN=3'd4), default SOF 8'hA5, and the STAT_W=16 constant.
- Sub-module uart_frame_buf: MAX_LEN x 8 register-file buffer with a synchronous write port and a registered read port, instantiated once.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03, m_ready=1 -> frame_ok pulse; m_data 11,22,33 on consecutive cycles; m_last only with 33; then IDLE, busy=0.
- Bad checksum: A5 02 10 20 00 (expected 0x32) -> err_chk pulse, m_valid never asserts, state returns to IDLE.
- Bad length: A5 00, then A5 11 with MAX_LEN=16 -> err_len pulse on each; following good frame A5 01 7E 7F accepted with frame_ok.
- Timeout: A5 02 55 then silence for TIMEOUT_TICKS s_ticks -> err_timeout on that tick; a coincident byte at the expiring tick suppresses the timeout.
- Backpressure and overrun: good 3-byte frame, m_ready held low 20 cycles with 2 rx bytes arriving -> m_data/m_last stable, two overrun pulses, then full drain when m_ready rises.
- Reset mid-PAYLOAD and stats: reset asserted after A5 04 01 -> all outputs 0 immediately (async). With UART_FRAME_STATS_EN defined, after 1 good and 3 error frames, stat_frames=1 and stat_errors=3.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive framing controller.
package uart_frame_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         STAT_W      = 16;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register file with a synchronous write port and a
// registered read port. Storage is not reset; only the read register is.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Store payload bytes as they arrive
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; holds its value while no new read is requested
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing controller: parses SOF/LEN/PAYLOAD/CHK frames,
// checks length and XOR checksum, enforces an inter-byte timeout and
// drains validated payloads over a valid/ready interface.
// Optional statistics counters are enabled by defining UART_FRAME_STATS_EN.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF           = SOF_DEFAULT,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 2560
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              frame_ok,
    output logic              err_len,
    output logic              err_chk,
    output logic              err_timeout,
    output logic              overrun,
    output logic              busy,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_errors
);

    localparam int          IW      = $clog2(MAX_LEN + 1);
    localparam int          AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] len_q, idx_q, rd_idx_q, rd_addr;
    logic [7:0]    chk_acc_q;
    logic [15:0]   to_cnt_q;
    logic          in_frame, expire, len_bad, xfer;
    logic          wr_en, rd_en;
    logic          frame_ok_nxt, err_len_nxt, err_chk_nxt, err_timeout_nxt, overrun_nxt;

    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign expire   = s_tick && (to_cnt_q == TO_LAST);
    assign len_bad  = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
    assign m_valid  = (state == DRAIN);
    assign busy     = (state != IDLE);
    assign xfer     = m_valid && m_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, buffer port control and pulse requests; a byte beats an expiring tick
    always_comb begin
        state_nxt       = state;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        rd_addr         = rd_idx_q;
        frame_ok_nxt    = 1'b0;
        err_len_nxt     = 1'b0;
        err_chk_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        overrun_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done_tick && rx_data == SOF) state_nxt = LEN;
            end
            LEN: begin
                if (rx_done_tick) begin
                    if (len_bad) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end else if (expire) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            PAYLOAD: begin
                if (rx_done_tick) begin
                    wr_en = 1'b1;
                    if (idx_q == len_q - 1'b1) state_nxt = CHK;
                end else if (expire) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            CHK: begin
                if (rx_done_tick) begin
                    if (rx_data == chk_acc_q) begin
                        frame_ok_nxt = 1'b1;
                        state_nxt    = DRAIN;
                        rd_en        = 1'b1;
                        rd_addr      = '0;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end else if (expire) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            DRAIN: begin
                overrun_nxt = rx_done_tick;
                if (xfer) begin
                    if (m_last) begin
                        state_nxt = IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Length, write index, running checksum, read index and last-beat flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            chk_acc_q <= '0;
            m_last    <= 1'b0;
        end else begin
            if (state == LEN && rx_done_tick) begin
                len_q     <= rx_data[IW-1:0];
                chk_acc_q <= rx_data;
                idx_q     <= '0;
            end
            if (wr_en) begin
                idx_q     <= idx_q + 1'b1;
                chk_acc_q <= chk_acc_q ^ rx_data;
            end
            if (rd_en) begin
                rd_idx_q <= rd_addr;
                m_last   <= (rd_addr == len_q - 1'b1);
            end else if (xfer && m_last) begin
                m_last <= 1'b0;
            end
        end
    end

    // Inter-byte timeout counter, only live while a frame is being received
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   to_cnt_q <= '0;
        else if (!in_frame || rx_done_tick || expire) to_cnt_q <= '0;
        else if (s_tick)                             to_cnt_q <= to_cnt_q + 16'd1;
    end

    // One-cycle status pulses, registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_ok    <= 1'b0;
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_ok    <= frame_ok_nxt;
            err_len     <= err_len_nxt;
            err_chk     <= err_chk_nxt;
            err_timeout <= err_timeout_nxt;
            overrun     <= overrun_nxt;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (m_data)
    );

`ifdef UART_FRAME_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Saturating good-frame and error counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_errors <= '0;
        end else begin
            if (frame_ok) stat_frames <= sat_inc(stat_frames);
            if (err_len || err_chk || err_timeout || overrun)
                stat_errors <= sat_inc(stat_errors);
        end
    end
`else
    assign stat_frames = '0;
    assign stat_errors = '0;
`endif

endmodule
